// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel generator.
interface vga_timing_gen_if;
    logic       pixEna;
    logic       HSync;
    logic       VSync;
    logic [9:0] HPix;
    logic [9:0] VPix;
    logic       blank;
    logic       frameStart;

    modport master (output pixEna, HSync, VSync, HPix, VPix, blank, frameStart);
    modport slave  (input  pixEna, HSync, VSync, HPix, VPix, blank, frameStart);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe from a clock-enable divider, h/v counters,
// and registered sync / 1-based coordinate outputs (0 = blanking).
module vga_timing_gen #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic             CLK,
    input  logic             CLR,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW    = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]    V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]    HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [DW-1:0] r_divcnt;
    logic [9:0]    r_hcnt;
    logic [9:0]    r_vcnt;
    logic [9:0]    r_hpix;
    logic [9:0]    r_vpix;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_blank;
    logic          r_frame_start;

    logic          w_pix_ena;
    logic [9:0]    w_hcnt_nxt;
    logic [9:0]    w_vcnt_nxt;
    logic          w_hvis;
    logic          w_vvis;

    assign w_pix_ena = (r_divcnt == DIV_LAST);

    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_vcnt_nxt = r_vcnt;
        if (w_pix_ena) begin
            if (r_hcnt == H_LAST) begin
                w_hcnt_nxt = '0;
                w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
            end else begin
                w_hcnt_nxt = r_hcnt + 10'd1;
            end
        end
    end

    // Outputs decode the next-state counters so they land on the same edge.
    assign w_hvis = (w_hcnt_nxt < H_VIS_C);
    assign w_vvis = (w_vcnt_nxt < V_VIS_C);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_divcnt      <= '0;
            r_hcnt        <= H_LAST;
            r_vcnt        <= V_LAST;
            r_hpix        <= '0;
            r_vpix        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_divcnt      <= w_pix_ena ? '0 : r_divcnt + DW'(1);
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_hpix        <= w_hvis ? w_hcnt_nxt + 10'd1 : '0;
            r_vpix        <= w_vvis ? w_vcnt_nxt + 10'd1 : '0;
            r_hsync       <= !((w_hcnt_nxt >= HS_BEG) && (w_hcnt_nxt < HS_END));
            r_vsync       <= !((w_vcnt_nxt >= VS_BEG) && (w_vcnt_nxt < VS_END));
            r_blank       <= !(w_hvis && w_vvis);
            r_frame_start <= w_pix_ena && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
        end
    end

    assign vga.pixEna     = w_pix_ena;
    assign vga.HSync      = r_hsync;
    assign vga.VSync      = r_vsync;
    assign vga.HPix       = r_hpix;
    assign vga.VPix       = r_vpix;
    assign vga.blank      = r_blank;
    assign vga.frameStart = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size 640x480 instance and a tiny-raster instance
// share clock and reset; expected samples are queued by cycle index.
module tb_vga_timing_gen;
    localparam int K_SNAP  = 0;
    localparam int K_PE    = 1;
    localparam int K_HSLO  = 2;
    localparam int K_VSLO  = 3;
    localparam int K_VIOL  = 4;
    localparam int K_FSCNT = 5;
    localparam int K_FSPER = 6;
    localparam int K_RPE   = 7;

    typedef struct {
        bit         rst;
        int         n;
        int         dut;
        int         kind;
        logic       pe, hs, vs, bl, fs;
        logic [9:0] hp, vp;
        int         val;
    } rec_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    always #5 CLK = ~CLK;

    vga_timing_gen_if u_if_full ();
    vga_timing_gen_if u_if_small ();

    vga_timing_gen #(
        .DIV(4), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
    ) u_full (
        .CLK(CLK),
        .CLR(CLR),
        .vga(u_if_full)
    );

    // 15 x 10 raster: hsync at hcnt 10..12, vsync at vcnt 7..8, frame = 600 CLK.
    vga_timing_gen #(
        .DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .CLK(CLK),
        .CLR(CLR),
        .vga(u_if_small)
    );

    rec_t  q[$];
    string qn[$];
    int    checks = 0;
    int    errors = 0;

    task automatic push_snap(input bit rst, input int n, input int d,
                             input logic pe, input logic [9:0] hp, input logic [9:0] vp,
                             input logic hs, input logic vs, input logic bl, input logic fs,
                             input string name);
        rec_t r;
        r.rst = rst; r.n = n; r.dut = d; r.kind = K_SNAP; r.val = 0;
        r.pe = pe; r.hp = hp; r.vp = vp; r.hs = hs; r.vs = vs; r.bl = bl; r.fs = fs;
        q.push_back(r);
        qn.push_back(name);
    endtask

    task automatic push_cnt(input bit rst, input int n, input int d, input int kind,
                            input int val, input string name);
        rec_t r;
        r.rst = rst; r.n = n; r.dut = d; r.kind = kind; r.val = val;
        r.pe = 1'b0; r.hp = '0; r.vp = '0; r.hs = 1'b0; r.vs = 1'b0; r.bl = 1'b0; r.fs = 1'b0;
        q.push_back(r);
        qn.push_back(name);
    endtask

    // Monitor: n counts cycles since reset release, rn counts cycles with CLR high.
    initial begin
        int         n, rn, a;
        logic       s_pe [2], s_hs [2], s_vs [2], s_bl [2], s_fs [2];
        logic [9:0] s_hp [2], s_vp [2];
        logic       p_pe [2], p_hs [2], p_vs [2], p_bl [2];
        logic [9:0] p_hp [2], p_vp [2];
        int         pe_cnt [2], hs_lo [2], vs_lo [2], viol [2];
        int         fs_cnt [2], fs_last [2], fs_per [2], rst_pe [2];
        rec_t       r;
        string      nm;
        logic [24:0] act, exp;
        n = 0; rn = 0;
        for (int unsigned d = 0; d < 2; d++) begin
            pe_cnt[d] = 0; hs_lo[d] = 0; vs_lo[d] = 0; viol[d] = 0;
            fs_cnt[d] = 0; fs_last[d] = 0; fs_per[d] = 0; rst_pe[d] = 0;
        end
        forever begin
            @(negedge CLK);
            s_pe[0] = u_if_full.pixEna;  s_hp[0] = u_if_full.HPix;  s_vp[0] = u_if_full.VPix;
            s_hs[0] = u_if_full.HSync;   s_vs[0] = u_if_full.VSync;  s_bl[0] = u_if_full.blank;
            s_fs[0] = u_if_full.frameStart;
            s_pe[1] = u_if_small.pixEna; s_hp[1] = u_if_small.HPix; s_vp[1] = u_if_small.VPix;
            s_hs[1] = u_if_small.HSync;  s_vs[1] = u_if_small.VSync; s_bl[1] = u_if_small.blank;
            s_fs[1] = u_if_small.frameStart;
            if (CLR) begin
                rn++;
                n = 0;
                for (int unsigned d = 0; d < 2; d++) begin
                    pe_cnt[d] = 0; hs_lo[d] = 0; vs_lo[d] = 0; viol[d] = 0;
                    fs_cnt[d] = 0; fs_last[d] = 0; fs_per[d] = 0;
                    if (rn >= 2 && s_pe[d] === 1'b1) rst_pe[d]++;
                end
            end else begin
                rn = 0;
                n++;
                for (int unsigned d = 0; d < 2; d++) begin
                    rst_pe[d] = 0;
                    if (s_pe[d] === 1'b1) pe_cnt[d]++;
                    if (s_hs[d] === 1'b0) hs_lo[d]++;
                    if (s_vs[d] === 1'b0) vs_lo[d]++;
                    if (s_fs[d] === 1'b1) begin
                        fs_cnt[d]++;
                        if (fs_last[d] != 0) fs_per[d] = n - fs_last[d];
                        fs_last[d] = n;
                    end
                    if (n >= 2 && p_pe[d] !== 1'b1 &&
                        ({s_hp[d], s_vp[d], s_hs[d], s_vs[d], s_bl[d]} !==
                         {p_hp[d], p_vp[d], p_hs[d], p_vs[d], p_bl[d]}))
                        viol[d]++;
                end
            end
            for (int unsigned d = 0; d < 2; d++) begin
                p_pe[d] = s_pe[d]; p_hp[d] = s_hp[d]; p_vp[d] = s_vp[d];
                p_hs[d] = s_hs[d]; p_vs[d] = s_vs[d]; p_bl[d] = s_bl[d];
            end
            while (q.size() > 0 && q[0].rst == CLR && q[0].n == (CLR ? rn : n)) begin
                r  = q.pop_front();
                nm = qn.pop_front();
                checks++;
                if (r.kind == K_SNAP) begin
                    act = {s_pe[r.dut], s_hp[r.dut], s_vp[r.dut], s_hs[r.dut],
                           s_vs[r.dut], s_bl[r.dut], s_fs[r.dut]};
                    exp = {r.pe, r.hp, r.vp, r.hs, r.vs, r.bl, r.fs};
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL %s: got pe=%b hp=%0d vp=%0d hs=%b vs=%b bl=%b fs=%b, expected pe=%b hp=%0d vp=%0d hs=%b vs=%b bl=%b fs=%b",
                                 nm, s_pe[r.dut], s_hp[r.dut], s_vp[r.dut], s_hs[r.dut],
                                 s_vs[r.dut], s_bl[r.dut], s_fs[r.dut],
                                 r.pe, r.hp, r.vp, r.hs, r.vs, r.bl, r.fs);
                    end
                end else begin
                    case (r.kind)
                        K_PE:    a = pe_cnt[r.dut];
                        K_HSLO:  a = hs_lo[r.dut];
                        K_VSLO:  a = vs_lo[r.dut];
                        K_VIOL:  a = viol[r.dut];
                        K_FSCNT: a = fs_cnt[r.dut];
                        K_FSPER: a = fs_per[r.dut];
                        default: a = rst_pe[r.dut];
                    endcase
                    if (a != r.val) begin
                        errors++;
                        $display("FAIL %s: got %0d, expected %0d", nm, a, r.val);
                    end
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge CLK);
        #1 CLR = 1'b1;
        repeat (cycles) @(posedge CLK);
        #1 CLR = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: got %0d records pending at timeout, expected 0", tag, q.size());
            q.delete();
            qn.delete();
        end
    endtask

    initial begin
        CLR = 1'b1;
        repeat (3) @(posedge CLK);
        #1 CLR = 1'b0;

        // Reset release, first line of the full raster, small raster frame.
        push_snap(0, 1,    0, 0, 0,   0, 1, 1, 1, 0, "f_reset_state");
        push_snap(0, 1,    1, 0, 0,   0, 1, 1, 1, 0, "s_reset_state");
        push_snap(0, 4,    0, 1, 0,   0, 1, 1, 1, 0, "f_first_strobe");
        push_snap(0, 5,    0, 0, 1,   1, 1, 1, 0, 1, "f_first_pixel");
        push_snap(0, 5,    1, 0, 1,   1, 1, 1, 0, 1, "s_first_pixel");
        push_snap(0, 6,    0, 0, 1,   1, 1, 1, 0, 0, "f_fs_cleared");
        push_snap(0, 9,    0, 0, 2,   1, 1, 1, 0, 0, "f_pixel2");
        push_snap(0, 45,   1, 0, 0,   1, 0, 1, 1, 0, "s_hsync_low");
        push_snap(0, 364,  1, 1, 0,   6, 1, 1, 1, 0, "s_last_vis_line");
        push_snap(0, 365,  1, 0, 1,   0, 1, 1, 1, 0, "s_vblank_start");
        push_snap(0, 425,  1, 0, 1,   0, 1, 0, 1, 0, "s_vsync_start");
        push_snap(0, 545,  1, 0, 1,   0, 1, 1, 1, 0, "s_vsync_end");
        push_cnt (0, 600,  1, K_VSLO, 120, "s_vsync_width");
        push_snap(0, 604,  1, 1, 0,   0, 1, 1, 1, 0, "s_frame_end");
        push_snap(0, 605,  1, 0, 1,   1, 1, 1, 0, 1, "s_frame2_start");
        push_cnt (0, 1000, 0, K_PE,   250, "f_strobe_count");
        push_cnt (0, 1300, 1, K_FSPER, 600, "s_frame_period");
        push_cnt (0, 1300, 1, K_FSCNT, 3,   "s_frame_count");
        push_snap(0, 2564, 0, 1, 640, 1, 1, 1, 0, 0, "f_hpix640");
        push_snap(0, 2565, 0, 0, 0,   1, 1, 1, 1, 0, "f_hblank_start");
        push_snap(0, 2628, 0, 1, 0,   1, 1, 1, 1, 0, "f_front_porch_end");
        push_snap(0, 2629, 0, 0, 0,   1, 0, 1, 1, 0, "f_hsync_start");
        push_snap(0, 3012, 0, 1, 0,   1, 0, 1, 1, 0, "f_hsync_last");
        push_snap(0, 3013, 0, 0, 0,   1, 1, 1, 1, 0, "f_hsync_end");
        push_snap(0, 3204, 0, 1, 0,   1, 1, 1, 1, 0, "f_line1_end");
        push_snap(0, 3205, 0, 0, 1,   2, 1, 1, 0, 0, "f_line2_start");
        push_cnt (0, 3300, 0, K_HSLO,  384, "f_hsync_width");
        push_cnt (0, 3300, 0, K_VIOL,  0,   "f_change_off_strobe");
        push_cnt (0, 3300, 0, K_FSCNT, 1,   "f_frame_count");
        push_cnt (0, 3300, 1, K_VIOL,  0,   "s_change_off_strobe");
        drain("phase_a");

        // Single-cycle reset mid-line at HPix=300.
        do_reset(1);
        push_snap(0, 1201, 0, 0, 300, 1, 1, 1, 0, 0, "f_hpix300");
        drain("pre_midline");
        do_reset(1);
        push_snap(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, "f_midline_reset");
        push_snap(0, 4, 0, 1, 0, 0, 1, 1, 1, 0, "f_midline_strobe");
        push_snap(0, 5, 0, 0, 1, 1, 1, 1, 0, 1, "f_midline_restart");
        push_snap(0, 5, 1, 0, 1, 1, 1, 1, 0, 1, "s_midline_restart");
        drain("midline");

        // Reset held 10 cycles while the small raster is in vsync.
        do_reset(1);
        push_snap(0, 430, 1, 0, 2, 0, 1, 0, 1, 0, "s_in_vsync");
        drain("pre_hold");
        push_snap(1, 2,  1, 0, 0, 0, 1, 1, 1, 0, "s_hold_first_edge");
        push_cnt (1, 10, 0, K_RPE, 0, "f_hold_no_strobe");
        push_cnt (1, 10, 1, K_RPE, 0, "s_hold_no_strobe");
        do_reset(10);
        push_snap(0, 1, 1, 0, 0, 0, 1, 1, 1, 0, "s_hold_release");
        push_snap(0, 4, 1, 1, 0, 0, 1, 1, 1, 0, "s_hold_strobe");
        push_snap(0, 5, 1, 0, 1, 1, 1, 1, 0, 1, "s_hold_restart");
        drain("hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
